// File: rtl/befehlsabruf_steuerung.sv
// rtl/befehlsabruf_steuerung.sv - instruction fetch sequencer: PC control, imem handshake, decoder hand-off
module befehlsabruf_steuerung #(
    parameter int ADR_W   = 26,
    parameter int DATEN_W = 32
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [ADR_W-1:0]   AktuellerPC,
    output logic               TaktSignal,
    output logic               SchreibSignal,
    output logic [ADR_W-1:0]   NeuerPC,
    output logic               SpeicherAnfrage,
    output logic [ADR_W-1:0]   SpeicherAdresse,
    input  logic               SpeicherBereit,
    input  logic [DATEN_W-1:0] SpeicherDaten,
    output logic               BefehlGueltig,
    output logic [DATEN_W-1:0] Befehl,
    output logic [ADR_W-1:0]   BefehlAdresse,
    input  logic               DekoderBereit,
    input  logic               SprungAnfrage,
    input  logic [ADR_W-1:0]   SprungZiel,
    input  logic               Anhalten,
    input  logic               Weiter
);

    typedef enum logic [2:0] {
        START   = 3'd0,
        ANFRAGE = 3'd1,
        WARTEN  = 3'd2,
        AUSGABE = 3'd3,
        HALT    = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic                 pending_q, pending_d;
    logic [ADR_W-1:0]     ziel_q, ziel_d;
    logic                 flush_q, flush_d;
    logic [ADR_W-1:0]     fetch_adr_q, fetch_adr_d;
    logic                 gueltig_q, gueltig_d;
    logic [DATEN_W-1:0]   befehl_q, befehl_d;
    logic [ADR_W-1:0]     befehl_adr_q, befehl_adr_d;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q      <= START;
            pending_q    <= 1'b0;
            ziel_q       <= '0;
            flush_q      <= 1'b0;
            fetch_adr_q  <= '0;
            gueltig_q    <= 1'b0;
            befehl_q     <= '0;
            befehl_adr_q <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            ziel_q       <= ziel_d;
            flush_q      <= flush_d;
            fetch_adr_q  <= fetch_adr_d;
            gueltig_q    <= gueltig_d;
            befehl_q     <= befehl_d;
            befehl_adr_q <= befehl_adr_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pending_d       = pending_q;
        ziel_d          = ziel_q;
        flush_d         = flush_q;
        fetch_adr_d     = fetch_adr_q;
        gueltig_d       = gueltig_q;
        befehl_d        = befehl_q;
        befehl_adr_d    = befehl_adr_q;
        TaktSignal      = 1'b0;
        SchreibSignal   = 1'b0;
        NeuerPC         = '0;
        SpeicherAnfrage = 1'b0;
        SpeicherAdresse = '0;

        case (state_q)
            START: state_d = ANFRAGE;

            ANFRAGE: begin
                if (Anhalten) begin
                    state_d = HALT;
                end else begin
                    SpeicherAnfrage = 1'b1;
                    TaktSignal      = 1'b1;
                    // A pending redirect loads the PC so it continues at target+1
                    if (pending_q) begin
                        SchreibSignal   = 1'b1;
                        NeuerPC         = ziel_q;
                        SpeicherAdresse = ziel_q;
                        pending_d       = 1'b0;
                    end else begin
                        SpeicherAdresse = AktuellerPC;
                    end
                    fetch_adr_d = SpeicherAdresse;
                    state_d     = WARTEN;
                end
            end

            WARTEN: begin
                if (SpeicherBereit) begin
                    // A redirect seen while waiting makes this response stale
                    if (flush_q || SprungAnfrage) begin
                        flush_d = 1'b0;
                        state_d = ANFRAGE;
                    end else begin
                        befehl_d     = SpeicherDaten;
                        befehl_adr_d = fetch_adr_q;
                        gueltig_d    = 1'b1;
                        state_d      = AUSGABE;
                    end
                end else if (SprungAnfrage) begin
                    flush_d = 1'b1;
                end
            end

            AUSGABE: begin
                // Accept wins over withdraw: a same-cycle handshake still consumes the word
                if (DekoderBereit || SprungAnfrage) begin
                    gueltig_d = 1'b0;
                    state_d   = ANFRAGE;
                end
            end

            HALT: begin
                if (Weiter) begin
                    state_d = ANFRAGE;
                end
            end

            default: state_d = START;
        endcase

        // Sampled in every state; the newest redirect overrides an older one
        if (SprungAnfrage) begin
            pending_d = 1'b1;
            ziel_d    = SprungZiel;
        end
    end

    assign BefehlGueltig = gueltig_q;
    assign Befehl        = befehl_q;
    assign BefehlAdresse = befehl_adr_q;

endmodule

// File: tb/tb_befehlsabruf_steuerung.sv
// tb/tb_befehlsabruf_steuerung.sv - randomized bench for befehlsabruf_steuerung with transaction-level model
module tb_befehlsabruf_steuerung;

    localparam int ADR_W   = 26;
    localparam int DATEN_W = 32;

    logic               Clock = 1'b0;
    logic               Reset = 1'b0;
    logic [ADR_W-1:0]   AktuellerPC;
    logic               TaktSignal;
    logic               SchreibSignal;
    logic [ADR_W-1:0]   NeuerPC;
    logic               SpeicherAnfrage;
    logic [ADR_W-1:0]   SpeicherAdresse;
    logic               SpeicherBereit = 1'b0;
    logic [DATEN_W-1:0] SpeicherDaten = '0;
    logic               BefehlGueltig;
    logic [DATEN_W-1:0] Befehl;
    logic [ADR_W-1:0]   BefehlAdresse;
    logic               DekoderBereit = 1'b0;
    logic               SprungAnfrage = 1'b0;
    logic [ADR_W-1:0]   SprungZiel = '0;
    logic               Anhalten = 1'b0;
    logic               Weiter = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    always #5 Clock = ~Clock;

    befehlsabruf_steuerung #(.ADR_W(ADR_W), .DATEN_W(DATEN_W)) dut (
        .Clock(Clock), .Reset(Reset), .AktuellerPC(AktuellerPC),
        .TaktSignal(TaktSignal), .SchreibSignal(SchreibSignal), .NeuerPC(NeuerPC),
        .SpeicherAnfrage(SpeicherAnfrage), .SpeicherAdresse(SpeicherAdresse),
        .SpeicherBereit(SpeicherBereit), .SpeicherDaten(SpeicherDaten),
        .BefehlGueltig(BefehlGueltig), .Befehl(Befehl), .BefehlAdresse(BefehlAdresse),
        .DekoderBereit(DekoderBereit), .SprungAnfrage(SprungAnfrage), .SprungZiel(SprungZiel),
        .Anhalten(Anhalten), .Weiter(Weiter)
    );

    // Program counter: advance on TaktSignal, load NeuerPC+1 when SchreibSignal
    logic [ADR_W-1:0] pc_q;
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)          pc_q <= '0;
        else if (TaktSignal) pc_q <= SchreibSignal ? NeuerPC + 1'b1 : pc_q + 1'b1;
    end
    assign AktuellerPC = pc_q;

    function automatic logic [31:0] mem_word(input logic [ADR_W-1:0] a);
        return 32'h5A3C_96E1 ^ {6'd0, a} ^ ({6'd0, a} << 9);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string w);
        check_eq({w, "_anfrage"}, SpeicherAnfrage, 0);
        check_eq({w, "_takt"},    TaktSignal,      0);
        check_eq({w, "_schreib"}, SchreibSignal,   0);
        check_eq({w, "_neuerpc"}, NeuerPC,         0);
        check_eq({w, "_adresse"}, SpeicherAdresse, 0);
        check_eq({w, "_gueltig"}, BefehlGueltig,   0);
        check_eq({w, "_befehl"},  Befehl,          0);
        check_eq({w, "_badr"},    BefehlAdresse,   0);
    endtask

    // Model: expected fetch address stream, redirect/flush rules, one queued instruction
    task automatic run_random(input int n, input int late);
        logic [ADR_W-1:0] exp_seq, pend_tgt, req_adr, iv_adr, mem_adr, exp_a;
        logic             pend, req_out, req_flush, iv, jump;
        logic [31:0]      iv_data;
        int               mem_wait, halt_left, late_left, n_req, n_hs;
        exp_seq = '0; pend_tgt = '0; req_adr = '0; iv_adr = '0; mem_adr = '0;
        pend = 1'b0; req_out = 1'b0; req_flush = 1'b0; iv = 1'b0; iv_data = '0;
        mem_wait = 0; halt_left = 0; late_left = late; n_req = 0; n_hs = 0;
        Anhalten = 1'b0; Weiter = 1'b0;
        #1 check_eq("start_no_req", SpeicherAnfrage, 0);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            #1;
            SpeicherBereit = 1'b0;
            SpeicherDaten  = $urandom;
            if (mem_wait > 0) begin
                mem_wait--;
                if (mem_wait == 0) begin
                    SpeicherBereit = 1'b1;
                    SpeicherDaten  = mem_word(mem_adr);
                end
            end else if (late_left > 0) begin
                late_left--;
                SpeicherBereit = 1'b1;
            end else if ($urandom_range(0, 15) == 0) begin
                SpeicherBereit = 1'b1;
            end
            DekoderBereit = ($urandom_range(0, 3) != 0);
            SprungAnfrage = (i > 0) && ($urandom_range(0, 11) == 0);
            SprungZiel    = ADR_W'($urandom_range(0, 1023));
            Weiter = 1'b0;
            if (halt_left > 0) begin
                halt_left--;
                Anhalten = 1'b1;
            end else if (Anhalten) begin
                Anhalten = 1'b0;
                Weiter   = 1'b1;
            end else if (i > 0 && $urandom_range(0, 39) == 0) begin
                Anhalten  = 1'b1;
                halt_left = $urandom_range(0, 7);
            end else begin
                Weiter = ($urandom_range(0, 29) == 0);
            end

            @(negedge Clock);
            jump = SprungAnfrage;
            if (i == 0) check_eq("first_req", SpeicherAnfrage, 1);

            check_eq("gueltig", BefehlGueltig, iv);
            if (iv) begin
                check_eq("befehl", Befehl, iv_data);
                check_eq("befehl_adr", BefehlAdresse, iv_adr);
                if (DekoderBereit) begin
                    n_hs++;
                    iv = 1'b0;
                end else if (jump) begin
                    iv = 1'b0;
                end
            end

            if (SpeicherBereit && req_out) begin
                if (!(req_flush || jump)) begin
                    iv      = 1'b1;
                    iv_adr  = req_adr;
                    iv_data = mem_word(req_adr);
                end
                req_out = 1'b0;
            end else if (req_out && jump) begin
                req_flush = 1'b1;
            end

            check_eq("takt", TaktSignal, SpeicherAnfrage);
            if (SpeicherAnfrage) begin
                n_req++;
                check_eq("req_busy", req_out | iv, 0);
                check_eq("req_halt", Anhalten, 0);
                exp_a = pend ? pend_tgt : exp_seq;
                check_eq("req_adr", SpeicherAdresse, exp_a);
                check_eq("schreib", SchreibSignal, pend);
                if (pend) check_eq("neuer_pc", NeuerPC, pend_tgt);
                exp_seq   = exp_a + 1'b1;
                pend      = 1'b0;
                req_out   = 1'b1;
                req_adr   = exp_a;
                req_flush = 1'b0;
                mem_wait  = $urandom_range(1, 3);
                mem_adr   = SpeicherAdresse;
            end else begin
                check_eq("schreib_idle", SchreibSignal, 0);
            end

            if (jump) begin
                pend     = 1'b1;
                pend_tgt = SprungZiel;
            end
        end
        check_eq("progress", (n_hs >= n / 20) && (n_req >= n_hs), 1);
    endtask

    initial begin
        bit found;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check_idle("reset");
        #2 Reset = 1'b1;
        run_random(2000, 0);

        // Get to WARTEN, then drop reset between clock edges
        Anhalten = 1'b0; SprungAnfrage = 1'b0; DekoderBereit = 1'b1; SpeicherBereit = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(posedge Clock);
            #1 Weiter = 1'b1;
            @(negedge Clock);
            if (SpeicherAnfrage) found = 1'b1;
        end
        check_eq("req_before_reset", found, 1);
        @(posedge Clock);
        #1 Weiter = 1'b0; SpeicherBereit = 1'b0;
        #2 Reset = 1'b0;
        #1 check_idle("async_reset");
        SpeicherBereit = 1'b1;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        #2 Reset = 1'b1;
        run_random(1500, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/befehlsabruf_steuerung.md
# befehlsabruf_steuerung

Fetch sequencer that drives the program counter and the instruction-memory read port. It decides when the program counter advances (`TaktSignal`) and when it loads a jump target (`SchreibSignal`/`NeuerPC`). It runs a single-outstanding request/response handshake with instruction memory and hands fetched words to the decoder with a valid/ready handshake. Jump redirects from execute, and halt/resume, are sequenced here.

## Interface
- `ADR_W`, 26, address width (matches program counter width)
- `DATEN_W`, 32, instruction word width
- `Clock`  in  1  system clock, rising edge
- `Reset`  in  1  asynchronous, active-low; 0 = reset
- `AktuellerPC`  in  ADR_W  current program counter value
- `TaktSignal`  out  1  PC advance enable
- `SchreibSignal`  out  1  PC load select; PC becomes `NeuerPC`+1
- `NeuerPC`  out  ADR_W  jump target to PC
- `SpeicherAnfrage`  out  1  one-cycle read request pulse
- `SpeicherAdresse`  out  ADR_W  read address, valid with `SpeicherAnfrage`
- `SpeicherBereit`  in  1  read data valid (≥1 cycle after request)
- `SpeicherDaten`  in  DATEN_W  read data
- `BefehlGueltig`  out  1  instruction valid to decoder
- `Befehl`  out  DATEN_W  instruction word
- `BefehlAdresse`  out  ADR_W  address of `Befehl`
- `DekoderBereit`  in  1  decoder accepts when high with `BefehlGueltig`
- `SprungAnfrage`  in  1  one-cycle redirect pulse from execute
- `SprungZiel`  in  ADR_W  redirect target, valid with `SprungAnfrage`
- `Anhalten`  in  1  level; blocks new requests
- `Weiter`  in  1  one-cycle resume pulse

## Operation
- States: START, ANFRAGE, WARTEN, AUSGABE, HALT. Reset → START. START → ANFRAGE unconditionally.
- ANFRAGE with `Anhalten`=1: no outputs asserted; → HALT.
- ANFRAGE with `Anhalten`=0, no pending jump: `SpeicherAnfrage`=1, `SpeicherAdresse`=`AktuellerPC`, `TaktSignal`=1, `SchreibSignal`=0; → WARTEN.
- ANFRAGE with `Anhalten`=0, pending jump: `SpeicherAdresse`=`NeuerPC`=target, `TaktSignal`=1, `SchreibSignal`=1; pending cleared; → WARTEN.
- The issued address is registered as the fetch address.
- WARTEN with `SpeicherBereit`=1 and no flush: capture `Befehl`=`SpeicherDaten` and `BefehlAdresse`=fetch address; `BefehlGueltig`=1 from next cycle; → AUSGABE.
- WARTEN with `SpeicherBereit`=1 and flush set: data discarded, flush cleared; → ANFRAGE.
- AUSGABE: `Befehl`/`BefehlAdresse` held stable while `DekoderBereit`=0.
- AUSGABE with `DekoderBereit`=1: handshake completes; `BefehlGueltig`=0 next cycle; → ANFRAGE.
- HALT: → ANFRAGE on `Weiter`=1.
- `SprungAnfrage` is sampled in every state and latches target into a one-deep pending register; a later pulse overwrites an earlier one.
- `SprungAnfrage` in WARTEN sets flush.
- `SprungAnfrage` in AUSGABE without `DekoderBereit`: `BefehlGueltig` withdrawn next cycle; → ANFRAGE.
- `SprungAnfrage` in AUSGABE with `DekoderBereit`=1 in the same cycle: handshake counts (instruction consumed once), then redirect applies.
- `SprungAnfrage` together with `SpeicherBereit` in WARTEN: response discarded.
- `SpeicherBereit` outside WARTEN is ignored.
- Pending jump is preserved across HALT.

## Timing
- Reset values: all outputs 0, `Befehl`/`BefehlAdresse` 0, pending and flush 0, state START. Clearing is immediate on `Reset` low, without a clock edge.
- First `SpeicherAnfrage` on the 2nd rising edge after `Reset` rises (START takes one cycle).
- `SpeicherAnfrage`, `TaktSignal`, `SchreibSignal`, `NeuerPC` are combinational from state, pending and `Anhalten`. Each is high exactly one cycle per request.
- `BefehlGueltig`, `Befehl`, `BefehlAdresse` are registered.
- Minimum 3 cycles per instruction (ANFRAGE, WARTEN with 1-cycle memory, AUSGABE with `DekoderBereit`=1).
- At most one request outstanding.

## Test plan
- Release reset with a Programmzahler instance, 1-cycle memory, decoder always ready → requests to 0,1,2 every 3 cycles; `BefehlAdresse` 0,1,2; `SchreibSignal` never high.
- Hold `DekoderBereit`=0 for 5 cycles in AUSGABE at address 1 → `BefehlGueltig`=1 and `Befehl` stable all 5 cycles; no `SpeicherAnfrage`; next request address 2.
- `SprungAnfrage` with target 0x100 in WARTEN, memory latency 3 → response dropped (no `BefehlGueltig`). Next request: address 0x100, `SchreibSignal`=1, `NeuerPC`=0x100. Following request: 0x101.
- `SprungAnfrage` with target 0x40 in the same cycle as `DekoderBereit`=1 in AUSGABE → exactly one handshake; next request address 0x40.
- `Anhalten`=1 before ANFRAGE, `SprungAnfrage` with target 0x20 during HALT, then `Weiter` → no requests during HALT; first request after `Weiter` at 0x20 with `SchreibSignal`=1.
- Drive `Reset` low mid-WARTEN between clock edges → all outputs 0 immediately. After release, a late `SpeicherBereit` arriving in START/ANFRAGE is ignored and the first request is to address 0.
